// File: rtl/clk_sw_pkg.sv
// rtl/clk_sw_pkg.sv - shared select codes, FSM encoding and helpers for clock_switch_ctrl
package clk_sw_pkg;

  localparam logic [1:0] SEL_800M  = 2'b00;
  localparam logic [1:0] SEL_500M  = 2'b01;
  localparam logic [1:0] SEL_1000M = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    DWELL  = 2'b10
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_sw_timer.sv
// rtl/clk_sw_timer.sv - loadable down-counter with zero flag, shared by the settle and dwell windows
module clk_sw_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so an idle controller keeps a quiet, known count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clock_switch_ctrl.sv
// rtl/clock_switch_ctrl.sv - request-driven select sequencer for the glitch-free clock_switch
module clock_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int MIN_DWELL     = 16,
  parameter int NUM_SRC       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic [1:0] clk_sel,
  output logic       busy,
  output logic       done,
  output logic       err_illegal
);

  localparam int CNT_W = $clog2(max_int(SETTLE_CYCLES, MIN_DWELL) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = (MIN_DWELL > 0) ? CNT_W'(MIN_DWELL - 1) : '0;
  localparam logic [2:0]       NUM_SRC_C   = 3'(NUM_SRC);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             sel_illegal;

  assign sel_illegal = ({1'b0, req_sel} >= NUM_SRC_C);

  clk_sw_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (sel_illegal) begin
            err_d = 1'b1;
          end else if (req_sel == sel_q) begin
            // Already on the requested source: acknowledge without a settle window.
            done_d = 1'b1;
          end else begin
            sel_d    = req_sel;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          done_d = 1'b1;
          if (MIN_DWELL == 0) begin
            state_d = IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = DWELL_LOAD;
            state_d  = DWELL;
          end
        end
      end
      DWELL: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_800M;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign clk_sel     = sel_q;
  assign done        = done_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb/tb_clock_switch_ctrl.sv - directed self-checking bench for clock_switch_ctrl
module tb_clock_switch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic [1:0] clk_sel;
  logic       busy;
  logic       done;
  logic       err_illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  clock_switch_ctrl #(
    .SETTLE_CYCLES (8),
    .MIN_DWELL     (16),
    .NUM_SRC       (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_sel     (req_sel),
    .req_ready   (req_ready),
    .clk_sel     (clk_sel),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic request(input logic [1:0] sel, output int waited);
    req_valid = 1'b1;
    req_sel   = sel;
    waited    = 0;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic watch(input int n, output int done_at, output int done_cnt, output int ready_low);
    done_at   = -1;
    done_cnt  = 0;
    ready_low = 0;
    for (int i = 0; i < n; i++) begin
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (!req_ready) ready_low++;
      @(negedge clk);
    end
  endtask

  initial begin
    int w, d_at, d_cnt, r_low;
    logic [1:0] seq [6];
    seq = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = 2'b00;
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_clk_sel", 32'(clk_sel), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err_illegal), 32'h0);

    request(2'b01, w);
    check("norm_wait", 32'(w), 32'd0);
    check("norm_clk_sel", 32'(clk_sel), 32'h1);
    check("norm_busy", 32'(busy), 32'h1);
    watch(30, d_at, d_cnt, r_low);
    check("norm_done_at", 32'(d_at), 32'd8);
    check("norm_done_cnt", 32'(d_cnt), 32'd1);
    check("norm_ready_low", 32'(r_low), 32'd24);
    check("norm_idle_busy", 32'(busy), 32'h0);

    request(2'b11, w);
    check("ill_err", 32'(err_illegal), 32'h1);
    check("ill_done", 32'(done), 32'h0);
    check("ill_busy", 32'(busy), 32'h0);
    check("ill_clk_sel", 32'(clk_sel), 32'h1);
    @(negedge clk);
    check("ill_err_once", 32'(err_illegal), 32'h0);

    request(2'b10, w);
    watch(30, d_at, d_cnt, r_low);
    check("pre_same_clk_sel", 32'(clk_sel), 32'h2);
    request(2'b10, w);
    check("same_done", 32'(done), 32'h1);
    check("same_busy", 32'(busy), 32'h0);
    check("same_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("same_done_once", 32'(done), 32'h0);
    check("same_busy_after", 32'(busy), 32'h0);

    request(2'b00, w);
    watch(30, d_at, d_cnt, r_low);
    check("b2b_start_sel", 32'(clk_sel), 32'h0);
    for (int k = 0; k < 6; k++) begin
      request(seq[k], w);
      check($sformatf("b2b_sel_%0d", k), 32'(clk_sel), 32'(seq[k]));
      check($sformatf("b2b_wait_%0d", k), 32'(w), (k == 0) ? 32'd0 : 32'd24);
    end
    watch(30, d_at, d_cnt, r_low);
    check("b2b_last_done_at", 32'(d_at), 32'd8);

    request(2'b10, w);
    check("mid_clk_sel", 32'(clk_sel), 32'h2);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_clk_sel", 32'(clk_sel), 32'h0);
    check("mid_async_busy", 32'(busy), 32'h0);
    check("mid_async_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    watch(30, d_at, d_cnt, r_low);
    check("mid_no_done", 32'(d_cnt), 32'd0);
    request(2'b01, w);
    check("post_wait", 32'(w), 32'd0);
    check("post_clk_sel", 32'(clk_sel), 32'h1);
    watch(30, d_at, d_cnt, r_low);
    check("post_done_at", 32'(d_at), 32'd8);
    check("post_ready_low", 32'(r_low), 32'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
